// File: rtl/approx_mult_pkg.sv
// Shared types, default geometry and the approximate low-row reference function
// for the approximate multiplier family.
package approx_mult_pkg;

  localparam int W_DEF = 8;
  localparam int L_DEF = 4;
  localparam int K_DEF = 7;
  localparam int HI_W  = 2 * W_DEF - L_DEF;
  localparam int LO_W  = W_DEF + L_DEF - 1;
  // Widest operand the reference function models.
  localparam int MAX_W = 16;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Column-wise OR of the low partial-product rows; columns below k are dropped.
  function automatic logic [2*MAX_W-1:0] lo_approx(input logic [MAX_W-1:0] x_lo,
                                                   input logic [MAX_W-1:0] y,
                                                   input int w, input int l, input int k);
    logic [2*MAX_W-1:0] r;
    logic [MAX_W-1:0]   ys;
    r = '0;
    for (int c = 0; c < 2 * MAX_W - 1; c++) begin
      for (int i = 0; i < MAX_W; i++) begin
        if (i < l && c >= i && (c - i) < w && c >= k) begin
          ys = y >> (c - i);
          if (x_lo[i] && ys[0]) r[c] = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_low_tree.sv
// Low-row partial product: exact y*x_lo, or the carry-free column-OR approximation
// with every column below K forced to zero.
module approx_low_tree #(
  parameter int W = 8,
  parameter int L = 4,
  parameter int K = 7
) (
  input  logic [L-1:0]   x_lo,
  input  logic [W-1:0]   y,
  input  logic           approx,
  output logic [W+L-1:0] lo
);

  localparam int COLS = W + L - 1;

  logic [COLS-1:0] lo_apx;

  genvar gi, gj;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [L-1:0] col_bits;
      for (gj = 0; gj < L; gj++) begin : g_row
        if ((gi - gj) >= 0 && (gi - gj) < W) begin : g_in
          assign col_bits[gj] = x_lo[gj] & y[gi-gj];
        end else begin : g_out
          assign col_bits[gj] = 1'b0;
        end
      end
      if (gi >= K) begin : g_keep
        assign lo_apx[gi] = |col_bits;
      end else begin : g_drop
        assign lo_apx[gi] = 1'b0;
      end
    end
  endgenerate

  // The exact low product needs one bit more than the approximate column span.
  assign lo = approx ? {1'b0, lo_apx} : ((W+L)'(y) * (W+L)'(x_lo));

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage approximate unsigned multiplier with valid/ready handshake;
// the whole pipe freezes when the output is valid and not accepted.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W = 8,
  parameter int L = 4,
  parameter int K = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           in_approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_z,
  output logic           out_approx
);

  localparam int H_W = 2 * W - L;
  localparam int L_W = W + L;

  logic           adv;
  logic           v1_q, v2_q, v3_q;
  logic [W-1:0]   x_q, y_q;
  mode_e          mode1_q, mode2_q, mode3_q;
  logic [H_W-1:0] hi_q, hi_d;
  logic [L_W-1:0] lo_q, lo_d;
  logic [2*W-1:0] z_q, z_d;

  assign adv      = !v3_q | out_ready;
  assign in_ready = adv;

  assign hi_d = H_W'(y_q) * H_W'(x_q[W-1:L]);

  approx_low_tree #(.W(W), .L(L), .K(K)) u_low_tree (
    .x_lo   (x_q[L-1:0]),
    .y      (y_q),
    .approx (mode1_q == MODE_APPROX),
    .lo     (lo_d)
  );

  // Approximate lo never exceeds the exact one, so the 2W-bit sum cannot overflow.
  assign z_d = ((2*W)'(hi_q) << L) + (2*W)'(lo_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      mode1_q <= MODE_EXACT;
      mode2_q <= MODE_EXACT;
      mode3_q <= MODE_EXACT;
      hi_q    <= '0;
      lo_q    <= '0;
      z_q     <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      x_q     <= in_x;
      y_q     <= in_y;
      mode1_q <= mode_e'(in_approx);
      v2_q    <= v1_q;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mode2_q <= mode1_q;
      v3_q    <= v2_q;
      z_q     <= z_d;
      mode3_q <= mode2_q;
    end
  end

  assign out_valid  = v3_q;
  assign out_z      = z_q;
  assign out_approx = (mode3_q == MODE_APPROX);

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe (W=8, L=4, K=7): hand-computed vectors,
// a random stalled stream against the package model, and reset mid-flight.
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        in_approx;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic        out_approx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(8), .L(4), .K(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_approx  (in_approx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_approx (out_approx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic [2*MAX_W-1:0] lo;
    logic [15:0]        hi;
    if (!m) return 16'(x) * 16'(y);
    hi = 16'(y) * 16'(x[7:4]);
    lo = lo_approx(16'(x[3:0]), 16'(y), 8, 4, 7);
    return (hi << 4) + lo[15:0];
  endfunction

  // Entered and left at posedge+1; pipeline assumed empty.
  task automatic send_and_check(input string tag, input logic [7:0] x, input logic [7:0] y,
                                input logic m, input logic [15:0] exp);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_approx = m;
    out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_z"}, 32'(out_z), 32'(exp));
    check({tag, "_mode"}, 32'(out_approx), 32'(m));
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  sx [20];
  logic [7:0]  sy [20];
  logic        sm [20];
  logic [15:0] sexp [20];

  initial begin
    int tx, rx, cyc;
    logic fire_in, fire_out, stalled;
    logic [15:0] held_z;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_approx = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_z", 32'(out_z), 32'd0);
    check("rst_mode", 32'(out_approx), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);

    send_and_check("ex_ff", 8'd255, 8'd255, 1'b0, 16'd65025);
    send_and_check("ap_ff", 8'd255, 8'd255, 1'b1, 16'd63120);
    send_and_check("ap_03c0", 8'h03, 8'hC0, 1'b1, 16'd384);
    send_and_check("ap_15_1", 8'd15, 8'd1, 1'b1, 16'd0);
    send_and_check("ap_16_3", 8'd16, 8'd3, 1'b1, 16'd48);

    // Random stream, alternating mode, random backpressure.
    for (int i = 0; i < 20; i++) begin
      sx[i]   = 8'($urandom_range(0, 255));
      sy[i]   = 8'($urandom_range(0, 255));
      sm[i]   = i[0];
      sexp[i] = model(sx[i], sy[i], sm[i]);
    end
    tx = 0; rx = 0; cyc = 0; stalled = 1'b0; held_z = '0;
    while (rx < 20 && cyc < 600) begin
      if (stalled) begin
        check("stall_vld", 32'(out_valid), 32'd1);
        check("stall_z", 32'(out_z), 32'(held_z));
      end
      in_valid  = (tx < 20);
      in_x      = (tx < 20) ? sx[tx] : 8'd0;
      in_y      = (tx < 20) ? sy[tx] : 8'd0;
      in_approx = (tx < 20) ? sm[tx] : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      stalled  = out_valid & !out_ready;
      held_z   = out_z;
      if (fire_out) begin
        if (rx < 20) begin
          check("stream_z", 32'(out_z), 32'(sexp[rx]));
          check("stream_mode", 32'(out_approx), 32'(sm[rx]));
        end
        rx++;
      end
      @(posedge clk);
      #1;
      if (fire_in) tx++;
      cyc++;
    end
    check("stream_count", 32'(rx), 32'd20);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("drain_vld", 32'(out_valid), 32'd0);

    // Fill the pipe with the output blocked, then reset mid-flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = 8'(i + 9); in_y = 8'd77; in_approx = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("full_rdy", 32'(in_ready), 32'd0);
    check("full_z", 32'(out_z), 32'd693);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_z", 32'(out_z), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    send_and_check("post_rst", 8'd5, 8'd7, 1'b0, 16'd35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
